// File: rtl/pf_egress_pkg.sv
// Shared types for the egress arbiter slice.
//   egress_state_t  : arbiter FSM states
//   FILLER_WORD     : data word of the beat that closes an aborted frame
//   axis_d_source_t : tdest-tagged stream from an ingress filter (tvalid/tdata/tdest/tlast)
//   axis_d_sink_t   : tready back to an ingress filter
//   axis_source_t   : plain egress stream (tvalid/tdata/tlast)
//   axis_sink_t     : downstream tready
package pf_egress_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        ABORT
    } egress_state_t;

    localparam logic [15:0] FILLER_WORD = 16'h0000;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic [1:0]  tdest;
        logic        tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_d_sink_t;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req         : request vector, one bit per ingress
//   last_grant  : index granted most recently; search starts just after it
//   grant       : first requester after last_grant in cyclic order
//   grant_valid : 1 when any request is present
module rr_arbiter #(
    parameter int NUM_INGRESS = 4,
    parameter int IDX_W       = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1
) (
    input  logic [NUM_INGRESS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       grant,
    output logic                   grant_valid
);

    int idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and a latch is inferred.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Offsets 1..N visit every index once, ending on last_grant itself,
        // so a lone requester is always re-granted.
        for (int k = 1; k <= NUM_INGRESS; k++) begin
            idx = (int'(last_grant) + k) % NUM_INGRESS;
            if (!grant_valid && req[idx]) begin
                grant       = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Per-egress-port frame arbiter. Merges the frames tagged with EGRESS_ID from
// NUM_INGRESS ingress filters onto one registered AXI-Stream output, one whole
// frame at a time, round-robin. A granted frame that starves mid-frame is
// closed with a filler beat (tlast=1) and its remainder is drained.
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   en             : 1 = new grants allowed; 0 = finish current frame, then idle
//   ingress_source : tvalid/tdata/tdest/tlast from each ingress filter
//   ingress_sink   : this instance's tready contribution per ingress
//   egress_source  : registered output stream
//   egress_sink    : downstream tready
//   timeout        : one-cycle pulse alongside the filler beat of an abort
//   busy           : 1 while a frame is granted or being aborted
module egress_arbiter
    import pf_egress_pkg::*;
#(
    parameter int         NUM_INGRESS       = 4,
    parameter logic [1:0] EGRESS_ID         = 2'd0,
    parameter int         TIMEOUT_CTR_WIDTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  axis_d_source_t ingress_source [NUM_INGRESS],
    output axis_d_sink_t   ingress_sink   [NUM_INGRESS],
    output axis_source_t   egress_source,
    input  axis_sink_t     egress_sink,
    output logic           timeout,
    output logic           busy
);

    localparam int IDX_W = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1;
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] CTR_MAX   = '1;
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] CTR_ABORT = CTR_MAX - 1'b1;

    egress_state_t                state, state_d;
    logic [IDX_W-1:0]             grant, grant_d;
    logic [IDX_W-1:0]             last_grant, last_grant_d;
    logic [NUM_INGRESS-1:0]       drain, drain_d;
    logic [TIMEOUT_CTR_WIDTH-1:0] ctr, ctr_d;
    axis_source_t                 out_q, out_d;
    logic                         timeout_q, timeout_d;

    logic [NUM_INGRESS-1:0] req;
    logic [IDX_W-1:0]       arb_grant;
    logic                   arb_valid;
    logic                   out_ready;
    axis_d_source_t         cur;

    assign out_ready     = !out_q.tvalid || egress_sink.tready;
    assign cur           = ingress_source[grant];
    assign egress_source = out_q;
    assign timeout       = timeout_q;
    assign busy          = (state != IDLE);

    always_comb begin
        for (int i = 0; i < NUM_INGRESS; i++) begin
            req[i] = ingress_source[i].tvalid
                  && (ingress_source[i].tdest == EGRESS_ID)
                  && !drain[i];
        end
    end

    rr_arbiter #(
        .NUM_INGRESS (NUM_INGRESS),
        .IDX_W       (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Only the granted source (and any draining one) ever sees tready; the
    // switch top ORs these across instances, so a stray ready would steal
    // beats destined for another egress port.
    always_comb begin
        for (int i = 0; i < NUM_INGRESS; i++) begin
            ingress_sink[i].tready = drain[i]
                                  || ((state == FWD) && (grant == IDX_W'(i)) && out_ready);
        end
    end

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        drain_d      = drain;
        ctr_d        = ctr;
        out_d        = out_q;
        timeout_d    = 1'b0;

        if (out_q.tvalid && egress_sink.tready) begin
            out_d.tvalid = 1'b0;
        end

        // Drained beats are discarded regardless of tdest; the tail ends on tlast.
        for (int i = 0; i < NUM_INGRESS; i++) begin
            if (drain[i] && ingress_source[i].tvalid && ingress_source[i].tlast) begin
                drain_d[i] = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                if (en && arb_valid) begin
                    grant_d = arb_grant;
                    ctr_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (cur.tvalid) begin
                    // A stalled output is backpressure, not starvation: ctr holds.
                    if (out_ready) begin
                        out_d = '{tvalid: 1'b1, tdata: cur.tdata, tlast: cur.tlast};
                        ctr_d = '0;
                        if (cur.tlast) begin
                            last_grant_d = grant;
                            state_d      = IDLE;
                        end
                    end
                end else begin
                    if (ctr != CTR_MAX) begin
                        ctr_d = ctr + 1'b1;
                    end
                    // This starved cycle brings ctr to its maximum.
                    if (ctr >= CTR_ABORT) begin
                        drain_d[grant] = 1'b1;
                        state_d        = ABORT;
                    end
                end
            end
            ABORT: begin
                if (out_ready) begin
                    out_d        = '{tvalid: 1'b1, tdata: FILLER_WORD, tlast: 1'b1};
                    timeout_d    = 1'b1;
                    last_grant_d = grant;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_INGRESS - 1);
            drain      <= '0;
            ctr        <= '0;
            out_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            drain      <= drain_d;
            ctr        <= ctr_d;
            out_q      <= out_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed self-checking bench for egress_arbiter (NUM_INGRESS=4, EGRESS_ID=0,
// TIMEOUT_CTR_WIDTH=3). Expected egress beats are pushed into a queue ahead of
// each scenario and compared in order as the downstream accepts them.
module tb_egress_arbiter;
    import pf_egress_pkg::*;

    localparam int         N     = 4;
    localparam logic [1:0] ID    = 2'd0;
    localparam logic [1:0] OTHER = 2'd1;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    axis_d_source_t src [N];
    axis_d_sink_t   snk [N];
    axis_source_t   egress_source;
    axis_sink_t     egress_sink;
    logic           timeout;
    logic           busy;
    logic [N-1:0]   rdy_vec;

    int n_checks = 0;
    int n_fail   = 0;
    int timeout_cnt = 0;
    logic [31:0] exp_q [$];

    egress_arbiter #(
        .NUM_INGRESS       (N),
        .EGRESS_ID         (ID),
        .TIMEOUT_CTR_WIDTH (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .ingress_source (src),
        .ingress_sink   (snk),
        .egress_source  (egress_source),
        .egress_sink    (egress_sink),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) rdy_vec[i] = snk[i].tready;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Egress monitor: a beat valid with tready high at a falling edge is taken
    // at the following rising edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (egress_source.tvalid && egress_sink.tready) begin
                if (exp_q.size() == 0)
                    check("extra_beat", {15'b0, egress_source.tlast, egress_source.tdata}, 32'hFFFF_FFFF);
                else
                    check("beat", {15'b0, egress_source.tlast, egress_source.tdata}, exp_q.pop_front());
            end
            if (timeout) timeout_cnt++;
        end
    end

    function automatic logic [15:0] word(input logic [15:0] base, input int k);
        return 16'(base * (k + 1));
    endfunction

    task automatic push_frame(input logic [15:0] base, input int nbeats, input bit with_last);
        for (int k = 0; k < nbeats; k++)
            exp_q.push_back({15'b0, with_last && (k == nbeats - 1), word(base, k)});
    endtask

    // Offers one frame on source s. Beat k carries base*(k+1); tvalid is held
    // low for gap_len cycles before beat gap_after.
    task automatic drive_frame(input int s, input logic [1:0] dest, input logic [15:0] base,
                               input int nbeats, input int gap_after, input int gap_len,
                               input bit with_last);
        int t;
        for (int k = 0; k < nbeats; k++) begin
            if (k == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
            src[s] = '{tvalid: 1'b1, tdata: word(base, k), tdest: dest,
                       tlast: with_last && (k == nbeats - 1)};
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!snk[s].tready && t < 200);
            if (t >= 200) check($sformatf("handshake_src%0d", s), 32'(t), 32'd0);
            @(posedge clk);
            #1;
            src[s].tvalid = 1'b0;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int changes;
        axis_source_t held;

        reset = 1'b0;
        en = 1'b1;
        egress_sink.tready = 1'b1;
        for (int i = 0; i < N; i++) src[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(egress_source.tvalid), 32'd0);
        check("rst_tdata", 32'(egress_source.tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_tready", 32'(rdy_vec), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        settle(2);

        // Single source, 4-beat frame, 2-cycle first-beat latency
        push_frame(16'h1111, 4, 1);
        fork
            drive_frame(0, ID, 16'h1111, 4, -1, 0, 1);
            begin
                n = 0;
                @(negedge clk);
                while (!egress_source.tvalid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("first_latency", 32'(n), 32'd2);
            end
        join
        settle(6);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Sources 1 and 2 contend: 1 then 2, no interleave; next round 3 then 0
        push_frame(16'h0101, 3, 1);
        push_frame(16'h0202, 3, 1);
        fork
            drive_frame(1, ID, 16'h0101, 3, -1, 0, 1);
            drive_frame(2, ID, 16'h0202, 3, -1, 0, 1);
        join
        settle(4);
        push_frame(16'h0303, 3, 1);
        push_frame(16'h0505, 3, 1);
        fork
            drive_frame(3, ID, 16'h0303, 3, -1, 0, 1);
            drive_frame(0, ID, 16'h0505, 3, -1, 0, 1);
        join
        settle(6);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Frame for another egress port: never acknowledged, nothing forwarded
        src[0] = '{tvalid: 1'b1, tdata: 16'hDEAD, tdest: OTHER, tlast: 1'b1};
        repeat (4) begin
            @(negedge clk);
            check("other_dest_tready", 32'(snk[0].tready), 32'd0);
            check("other_dest_out", 32'(egress_source.tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        src[0] = '0;
        settle(2);

        // Starvation abort on source 0 while source 1 waits
        t0 = timeout_cnt;
        push_frame(16'h1000, 2, 0);
        exp_q.push_back({15'b0, 1'b1, 16'h0000});
        push_frame(16'h0011, 3, 1);
        fork
            drive_frame(0, ID, 16'h1000, 5, 2, 7, 1);
            begin
                settle(3);
                drive_frame(1, ID, 16'h0011, 3, -1, 0, 1);
            end
        join
        settle(6);
        check("abort_timeout_pulses", 32'(timeout_cnt - t0), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("abort_drain_clear", 32'(rdy_vec), 32'd0);

        // Downstream stall for 20 cycles mid-frame
        t0 = timeout_cnt;
        push_frame(16'h0202, 4, 1);
        fork
            drive_frame(2, ID, 16'h0202, 4, -1, 0, 1);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!egress_source.tvalid && n < 50);
                @(posedge clk);
                #1;
                egress_sink.tready = 1'b0;
                @(negedge clk);
                held = egress_source;
                changes = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (egress_source !== held) changes++;
                end
                check("stall_data", 32'(held.tdata), 32'h0404);
                check("stall_hold", 32'(changes), 32'd0);
                check("stall_busy", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
                egress_sink.tready = 1'b1;
            end
        join
        settle(6);
        check("stall_no_timeout", 32'(timeout_cnt - t0), 32'd0);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // en low: requester waits without a grant until en returns
        en = 1'b0;
        push_frame(16'h0707, 2, 1);
        fork
            drive_frame(1, ID, 16'h0707, 2, -1, 0, 1);
            begin
                repeat (6) @(negedge clk);
                check("en_low_busy", 32'(busy), 32'd0);
                check("en_low_tready", 32'(snk[1].tready), 32'd0);
                @(posedge clk);
                #1;
                en = 1'b1;
            end
        join
        settle(6);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame with a drain pending on source 3
        t0 = timeout_cnt;
        push_frame(16'h0303, 2, 0);
        exp_q.push_back({15'b0, 1'b1, 16'h0000});
        drive_frame(3, ID, 16'h0303, 2, -1, 0, 0);
        settle(10);
        check("pre_rst_timeout", 32'(timeout_cnt - t0), 32'd1);
        check("pre_rst_drain_ready", 32'(snk[3].tready), 32'd1);
        egress_sink.tready = 1'b0;
        src[1] = '{tvalid: 1'b1, tdata: 16'h0B0B, tdest: ID, tlast: 1'b0};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!egress_source.tvalid && n < 20);
        check("pre_rst_held", 32'(egress_source.tdata), 32'h0B0B);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(egress_source.tvalid), 32'd0);
        check("mid_rst_tdata", 32'(egress_source.tdata), 32'd0);
        check("mid_rst_tlast", 32'(egress_source.tlast), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tready", 32'(rdy_vec), 32'd0);
        src[1] = '0;
        egress_sink.tready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        settle(2);
        push_frame(16'h3030, 3, 1);
        drive_frame(3, ID, 16'h3030, 3, -1, 0, 1);
        settle(6);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
